dmem_lsu: RTL
=============

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 14, as the SRAM word-address width.
REQ-002 The block SHALL use one clock, clk, and an asynchronous, active-high reset, rst.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  access request
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  illegal or unsupported access
- DM_OE  out  1  SRAM read enable
- DM_WEB  out  4  active-low byte write enables; 4'hF = no write
- DM_addr  out  ADDR_W  SRAM word address
- DM_DI  out  32  SRAM write data
- DM_DO  in  32  SRAM read data, valid the cycle after the address

Function
REQ-004 FSM states SHALL be IDLE, ACC1, ACC2, CAP, DONE; req_ready = 1 only in IDLE.
REQ-005 In IDLE, req_valid SHALL latch all request fields; later input changes are ignored until the next IDLE.
REQ-006 Legal loads SHALL be 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores SHALL be 000 SB, 001 SH, 010 SW.
REQ-007 Any other funct3 SHALL go IDLE->DONE with rsp_err = 1 and no SRAM access.
REQ-008 ACC1 SHALL drive:
- DM_addr = addr[ADDR_W+1:2]
- DM_OE = ~write
- DM_WEB = ~(byte lanes of the first word)
- DM_DI = wdata << 8*addr[1:0]
REQ-009 From ACC1, a word-crossing access SHALL go to ACC2; otherwise it SHALL go to CAP.
REQ-010 ACC2 SHALL drive:
- DM_addr = first word address + 1, wrapping modulo 2^ADDR_W
- DM_OE = ~write
- remaining lanes enabled from lane 0
- DM_DI = wdata >> 8*(4 - addr[1:0])
REQ-011 ACC2 SHALL register DM_DO as the low word.
REQ-012 CAP SHALL register DM_DO as the final word, drive DM_OE = 0 and DM_WEB = 4'hF, and go to DONE.
REQ-013 DONE SHALL pulse rsp_valid for one cycle and then return to IDLE.
REQ-014 rsp_rdata SHALL be ({high word, low word} >> 8*addr[1:0]) truncated to the access width, then sign-extended for LB/LH and zero-extended for LBU/LHU.
REQ-015 Latency from the accepting edge to rsp_valid SHALL be 3 cycles for a single-word access, 4 for a split access, and 1 for an error.
REQ-016 Outside ACC1 and ACC2, DM_OE SHALL be 0 and DM_WEB SHALL be 4'hF.
REQ-017 There is no response back-pressure; the consumer SHALL accept rsp_valid unconditionally.

Reset
REQ-018 rst SHALL force: state IDLE, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, DM_OE = 0, DM_WEB = 4'hF, DM_addr = 0, DM_DI = 0.
REQ-019 rst asserted mid-access SHALL abort the access with no response and no further writes; the lanes of a split store already written remain written.

Configuration
REQ-020 With MISALIGN_SPLIT_EN defined, word-crossing LH/LHU/SH (offset 3) and LW/SW (offset 1..3) SHALL execute as two SRAM accesses via ACC2.
REQ-021 Without MISALIGN_SPLIT_EN:
- any access not naturally aligned (halfword addr[0] = 1, word addr[1:0] != 0) SHALL take the REQ-007 error path;
- ACC2 SHALL be unreachable.
- Naturally aligned behaviour SHALL be identical in both builds.

Structure
REQ-022 Package lsu_pkg SHALL hold the funct3 encodings, the state enum, and WEB_NONE = 4'hF.
REQ-023 Lane shifting and sign/zero extension SHALL live in a combinational sub-module, lsu_align, instantiated once.

Verification
REQ-024 A bench SHALL cover these scenarios:
- SW addr 0x0000_0104, wdata 0xDEADBEEF -> ACC1: DM_addr 0x041, DM_WEB 4'h0, DM_DI 0xDEADBEEF; rsp_valid 3 cycles after accept, rsp_err 0.
- SB addr 0x0000_0002, wdata 0x000000A5 -> DM_WEB 4'b1011, DM_DI 0x00A50000.
- LB addr 0x0000_0003, SRAM word 0x80FF_FF00 -> rsp_rdata 0xFFFFFF80; LBU at the same address -> 0x00000080.
- With MISALIGN_SPLIT_EN, LW addr 0x0000_0006, words 0x22221111 (word 1) and 0x44443333 (word 2) -> DM_addr 0x001 then 0x002, rsp_rdata 0x33332222, latency 4; without the macro -> rsp_err 1, DM_OE never 1.
- funct3 3'b011 load -> rsp_err 1 one cycle after accept, no SRAM activity; req_valid held high while busy is not accepted.
- rst asserted in ACC2 of a split SW -> DM_WEB 4'hF immediately, no rsp_valid, req_ready 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 encodings,
// FSM state type, the idle byte-write-enable value and request legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] WEB_NONE = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        ACC1,
        ACC2,
        CAP,
        DONE
    } lsu_state_e;

    function automatic logic f3Legal(input logic write, input logic [2:0] f3);
        if (write) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Natural alignment only depends on the access size bits of funct3.
    function automatic logic f3Aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return ~off[0];
            2'b10:   return off == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-lane mask and store data shifted across two
// words, plus load data extraction with sign/zero extension.
module lsu_align import lsu_pkg::*; (
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_loWord,
    input  logic [31:0] i_hiWord,
    output logic [7:0]  o_laneMask,
    output logic [63:0] o_wideData,
    output logic [31:0] o_rdata
);

    logic [3:0]  w_baseMask;
    logic [31:0] w_loadWord;

    always_comb begin
        case (i_funct3[1:0])
            2'b00:   w_baseMask = 4'b0001;
            2'b01:   w_baseMask = 4'b0011;
            default: w_baseMask = 4'b1111;
        endcase
    end

    // Lanes [3:0] belong to the first word, lanes [7:4] spill into the next one.
    assign o_laneMask = {4'b0000, w_baseMask} << i_offset;
    assign o_wideData = {32'h0, i_wdata} << {i_offset, 3'b000};
    assign w_loadWord = 32'({i_hiWord, i_loWord} >> {i_offset, 3'b000});

    always_comb begin
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_loadWord[7]}}, w_loadWord[7:0]};
            F3_H:    o_rdata = {{16{w_loadWord[15]}}, w_loadWord[15:0]};
            F3_BU:   o_rdata = {24'h0, w_loadWord[7:0]};
            F3_HU:   o_rdata = {16'h0, w_loadWord[15:0]};
            default: o_rdata = w_loadWord;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// RV32I load/store unit in front of a synchronous word-wide SRAM.
// Define MISALIGN_SPLIT_EN to execute word-crossing accesses as two SRAM cycles.
module dmem_lsu import lsu_pkg::*; #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              DM_OE,
    output logic [3:0]        DM_WEB,
    output logic [ADDR_W-1:0] DM_addr,
    output logic [31:0]       DM_DI,
    input  logic [31:0]       DM_DO
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    lsu_state_e        r_state;
    logic              r_write;
    logic [2:0]        r_funct3;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_lo;

    logic              w_idle;
    logic [2:0]        w_funct3;
    logic [1:0]        w_offset;
    logic [31:0]       w_wdata;
    logic [31:0]       w_loWord;
    logic [31:0]       w_hiWord;
    logic [7:0]        w_laneMask;
    logic [63:0]       w_wideData;
    logic [31:0]       w_rdata;
    logic              w_cross;
    logic              w_reject;
    logic              w_goAcc2;
    logic              w_unused;

    // In IDLE the aligner looks at the incoming request so ACC1 outputs can be
    // registered on the accepting edge; afterwards it uses the latched copy.
    assign w_idle   = (r_state == IDLE);
    assign w_funct3 = w_idle ? req_funct3    : r_funct3;
    assign w_offset = w_idle ? req_addr[1:0] : r_addr[1:0];
    assign w_wdata  = w_idle ? req_wdata     : r_wdata;
    assign w_cross  = |w_laneMask[7:4];
    assign w_loWord = w_cross ? r_lo  : DM_DO;
    assign w_hiWord = w_cross ? DM_DO : 32'h0;

    assign req_ready = w_idle;
    assign w_unused  = ^req_addr[31:ADDR_W+2];

`ifdef MISALIGN_SPLIT_EN
    assign w_reject = !f3Legal(req_write, req_funct3);
    assign w_goAcc2 = w_cross;
`else
    assign w_reject = !f3Legal(req_write, req_funct3) ||
                      !f3Aligned(req_funct3, req_addr[1:0]);
    assign w_goAcc2 = 1'b0;
`endif

    lsu_align u_align (
        .i_funct3   (w_funct3),
        .i_offset   (w_offset),
        .i_wdata    (w_wdata),
        .i_loWord   (w_loWord),
        .i_hiWord   (w_hiWord),
        .o_laneMask (w_laneMask),
        .o_wideData (w_wideData),
        .o_rdata    (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_write   <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr    <= '0;
            r_wdata   <= 32'h0;
            r_lo      <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            DM_OE     <= 1'b0;
            DM_WEB    <= WEB_NONE;
            DM_addr   <= '0;
            DM_DI     <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr[ADDR_W+1:0];
                        r_wdata  <= req_wdata;
                        if (w_reject) begin
                            r_state   <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else begin
                            r_state <= ACC1;
                            DM_addr <= req_addr[ADDR_W+1:2];
                            DM_OE   <= ~req_write;
                            DM_WEB  <= req_write ? ~w_laneMask[3:0] : WEB_NONE;
                            DM_DI   <= w_wideData[31:0];
                        end
                    end
                end
                ACC1: begin
                    if (w_goAcc2) begin
                        r_state <= ACC2;
                        DM_addr <= DM_addr + ADDR_ONE;
                        DM_OE   <= ~r_write;
                        DM_WEB  <= r_write ? ~w_laneMask[7:4] : WEB_NONE;
                        DM_DI   <= w_wideData[63:32];
                    end else begin
                        r_state <= CAP;
                        DM_OE   <= 1'b0;
                        DM_WEB  <= WEB_NONE;
                    end
                end
                ACC2: begin
                    r_state <= CAP;
                    r_lo    <= DM_DO;
                    DM_OE   <= 1'b0;
                    DM_WEB  <= WEB_NONE;
                end
                CAP: begin
                    // DM_DO here is the final word; extraction happens combinationally.
                    r_state   <= DONE;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= r_write ? 32'h0 : w_rdata;
                end
                DONE: begin
                    r_state   <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
